// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game states and default screen/paddle geometry
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        POINT,
        OVER
    } game_state_t;

    localparam int POS_W_DEF        = 10;
    localparam int H_RES_DEF        = 640;
    localparam int V_RES_DEF        = 480;
    localparam int BALL_R_DEF       = 4;
    localparam int PAD_HALF_H_DEF   = 24;
    localparam int PAD_L_X_DEF      = 16;
    localparam int PAD_R_X_DEF      = 624;
    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;

    localparam int SCORE_W = 4;

endpackage

// File: rtl/pong_score_counter.sv
// rtl/pong_score_counter.sv - per-player saturating score counter
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous clear to 0 (new game), wins over inc
//   inc        add one point, holds at WIN_SCORE
//   count      current score
//   at_win     count has reached WIN_SCORE
module pong_score_counter
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               at_win
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != WIN)) begin
            count <= count + 1'b1;
        end
    end

    assign at_win = (count == WIN);

endmodule

// File: rtl/ball_collision_scorer.sv
// rtl/ball_collision_scorer.sv - per-frame collision decisions, serve timing and scoring
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   start                    one-cycle pulse, begins a new game from IDLE/OVER
//   ball_x, ball_y           ball centre pixel
//   ball_dx, ball_dy         ball direction (1 = right / down)
//   paddle_l_y, paddle_r_y   paddle centres
//   bounce_x, bounce_y       registered one-cycle pulses to the ball tracker
//   serve, serve_dir         registered serve pulse and launch direction (1 = right)
//   score_l, score_r         player scores
//   game_over, winner        game finished, winner valid with it (1 = right)
module ball_collision_scorer
    import pong_pkg::*;
#(
    parameter int POS_W        = POS_W_DEF,
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int BALL_R       = BALL_R_DEF,
    parameter int PAD_HALF_H   = PAD_HALF_H_DEF,
    parameter int PAD_L_X      = PAD_L_X_DEF,
    parameter int PAD_R_X      = PAD_R_X_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [POS_W-1:0]   ball_x,
    input  logic [POS_W-1:0]   ball_y,
    input  logic               ball_dx,
    input  logic               ball_dy,
    input  logic [POS_W-1:0]   paddle_l_y,
    input  logic [POS_W-1:0]   paddle_r_y,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic               serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    // One extra bit so "x - r" near the left/top edge goes negative instead of wrapping.
    localparam int SW    = POS_W + 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    typedef logic signed [SW-1:0] spos_t;

    localparam spos_t S_ZERO      = '0;
    localparam spos_t S_BALL_R    = spos_t'(BALL_R);
    localparam spos_t S_PAD_L_X   = spos_t'(PAD_L_X);
    localparam spos_t S_PAD_R_X   = spos_t'(PAD_R_X);
    localparam spos_t S_H_MAX     = spos_t'(H_RES - 1);
    localparam spos_t S_V_MAX     = spos_t'(V_RES - 1);
    localparam spos_t S_PAD_REACH = spos_t'(PAD_HALF_H + BALL_R);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    // ------------------------------------------------------------------
    // Collision comparators
    // ------------------------------------------------------------------
    spos_t sx, sy, spl, spr;
    spos_t x_lo, x_hi, y_lo, y_hi;
    spos_t dl, dr, adl, adr;
    logic  wall_y, hit_l, hit_r, miss_l, miss_r, paddle_hit;

    assign sx  = $signed({1'b0, ball_x});
    assign sy  = $signed({1'b0, ball_y});
    assign spl = $signed({1'b0, paddle_l_y});
    assign spr = $signed({1'b0, paddle_r_y});

    assign x_lo = sx - S_BALL_R;
    assign x_hi = sx + S_BALL_R;
    assign y_lo = sy - S_BALL_R;
    assign y_hi = sy + S_BALL_R;

    assign dl  = sy - spl;
    assign dr  = sy - spr;
    assign adl = dl[SW-1] ? -dl : dl;
    assign adr = dr[SW-1] ? -dr : dr;

    assign wall_y = (!ball_dy && (y_lo <= S_ZERO)) ||
                    ( ball_dy && (y_hi >= S_V_MAX));

    // The ball centre must still be in front of the inner face; once it is
    // behind the paddle only the miss check applies.
    assign hit_l = !ball_dx && (x_lo <= S_PAD_L_X) && (sx >= S_PAD_L_X) &&
                   (adl <= S_PAD_REACH);
    assign hit_r =  ball_dx && (x_hi >= S_PAD_R_X) && (sx <= S_PAD_R_X) &&
                   (adr <= S_PAD_REACH);

    assign miss_l = !ball_dx && (x_lo <= S_ZERO);
    assign miss_r =  ball_dx && (x_hi >= S_H_MAX);

    assign paddle_hit = hit_l || hit_r;

    // ------------------------------------------------------------------
    // Score counters
    // ------------------------------------------------------------------
    logic clr, inc_l, inc_r, at_win_l, at_win_r;

    pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_l (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .inc    (inc_l),
        .count  (score_l),
        .at_win (at_win_l)
    );

    pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_r (
        .clk    (clk),
        .rst    (rst),
        .clear  (clr),
        .inc    (inc_r),
        .count  (score_r),
        .at_win (at_win_r)
    );

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    game_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bx_q, bx_d, by_q, by_d, serve_q, serve_d;
    logic             serve_dir_q, serve_dir_d;
    logic             winner_q, winner_d;
    logic             scorer_q, scorer_d;   // 1 = right player took the last point

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bx_q        <= 1'b0;
            by_q        <= 1'b0;
            serve_q     <= 1'b0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
            scorer_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            serve_q     <= serve_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            scorer_q    <= scorer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bx_d        = 1'b0;
        by_d        = 1'b0;
        serve_d     = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        scorer_d    = scorer_q;
        clr         = 1'b0;
        inc_l       = 1'b0;
        inc_r       = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    clr         = 1'b1;
                    serve_dir_d = 1'b1;
                    winner_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = SERVE_WAIT;
                end
            end

            SERVE_WAIT: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        serve_d = 1'b1;
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            PLAY: begin
                if (frame_tick) begin
                    if (paddle_hit) begin
                        bx_d = 1'b1;
                        by_d = wall_y;
                    end else if (miss_l || miss_r) begin
                        // Point to the opposite side; next serve heads at the loser.
                        inc_r       = miss_l;
                        inc_l       = miss_r;
                        scorer_d    = miss_l;
                        serve_dir_d = miss_r;
                        state_d     = POINT;
                    end else begin
                        by_d = wall_y;
                    end
                end
            end

            POINT: begin
                if (at_win_l || at_win_r) begin
                    winner_d = scorer_q;
                    state_d  = OVER;
                end else begin
                    cnt_d   = '0;
                    state_d = SERVE_WAIT;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bounce_x  = bx_q;
    assign bounce_y  = by_q;
    assign serve     = serve_q;
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_ball_collision_scorer.sv
// tb/tb_ball_collision_scorer.sv - self-checking bench for ball_collision_scorer
module tb_ball_collision_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic [9:0] ball_y = 10'd240;
    logic       ball_dx = 1'b0;
    logic       ball_dy = 1'b0;
    logic [9:0] paddle_l_y = 10'd240;
    logic [9:0] paddle_r_y = 10'd240;
    logic       bounce_x, bounce_y, serve, serve_dir, game_over, winner;
    logic [3:0] score_l, score_r;

    int checks   = 0;
    int failures = 0;
    int neg_cnt  = 0;

    ball_collision_scorer dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_dx    (ball_dx),
        .ball_dy    (ball_dy),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    tgt;
        logic  bx;
        logic  by;
        logic  sv;
        logic  sd;
        string name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [9:0] pl;
        logic [9:0] pr;
        logic       bx;
        logic       by;
        string      name;
    } vec_t;

    vec_t vecs[22];

    // Pulse monitor: every pulse must match a queued expectation on its negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_cnt = neg_cnt + 1;
            if (sb.size() > 0 && sb[0].tgt == neg_cnt) begin
                e = sb.pop_front();
                checks = checks + 1;
                if ({bounce_x, bounce_y, serve} !== {e.bx, e.by, e.sv} ||
                    (e.sv && serve_dir !== e.sd)) begin
                    failures = failures + 1;
                    $display("FAIL %s: got bx=%b by=%b serve=%b dir=%b, expected bx=%b by=%b serve=%b dir=%b",
                             e.name, bounce_x, bounce_y, serve, serve_dir, e.bx, e.by, e.sv, e.sd);
                end
            end else if (bounce_x || bounce_y || serve) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse: got bx=%b by=%b serve=%b at negedge %0d, expected none",
                         bounce_x, bounce_y, serve, neg_cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_tick(input logic [9:0] x, input logic [9:0] y,
                              input logic dx, input logic dy,
                              input logic [9:0] pl, input logic [9:0] pr,
                              input logic ebx, input logic eby,
                              input logic esv, input logic esd, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        ball_x = x; ball_y = y; ball_dx = dx; ball_dy = dy;
        paddle_l_y = pl; paddle_r_y = pr;
        frame_tick = 1'b1;
        e.tgt = neg_cnt + 1; e.bx = ebx; e.by = eby; e.sv = esv; e.sd = esd; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        @(negedge clk);
        #2;
    endtask

    task automatic serve_wait(input logic dir);
        for (int i = 1; i <= 60; i++)
            drive_tick(10'd320, 10'd240, 1'b0, 1'b0, 10'd240, 10'd240,
                       1'b0, 1'b0, (i == 60), dir, (i == 60) ? "serve" : "serve_wait");
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{10'd320, 10'd3,   1'b1, 1'b0, 10'd240, 10'd240, 1'b0, 1'b1, "top_wall"};
        vecs[1]  = '{10'd320, 10'd3,   1'b1, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, "top_wall_dy1"};
        vecs[2]  = '{10'd320, 10'd4,   1'b1, 1'b0, 10'd240, 10'd240, 1'b0, 1'b1, "top_edge"};
        vecs[3]  = '{10'd320, 10'd5,   1'b1, 1'b0, 10'd240, 10'd240, 1'b0, 1'b0, "top_clear"};
        vecs[4]  = '{10'd320, 10'd476, 1'b0, 1'b1, 10'd240, 10'd240, 1'b0, 1'b1, "bot_wall"};
        vecs[5]  = '{10'd320, 10'd475, 1'b0, 1'b1, 10'd240, 10'd240, 1'b0, 1'b1, "bot_edge"};
        vecs[6]  = '{10'd320, 10'd474, 1'b0, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, "bot_clear"};
        vecs[7]  = '{10'd20,  10'd200, 1'b0, 1'b1, 10'd220, 10'd240, 1'b1, 1'b0, "pad_l_hit"};
        vecs[8]  = '{10'd20,  10'd200, 1'b0, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, "pad_l_far"};
        vecs[9]  = '{10'd20,  10'd200, 1'b0, 1'b1, 10'd228, 10'd240, 1'b1, 1'b0, "pad_l_reach"};
        vecs[10] = '{10'd20,  10'd200, 1'b0, 1'b1, 10'd229, 10'd240, 1'b0, 1'b0, "pad_l_reach_out"};
        vecs[11] = '{10'd21,  10'd200, 1'b0, 1'b1, 10'd200, 10'd240, 1'b0, 1'b0, "pad_l_short"};
        vecs[12] = '{10'd16,  10'd200, 1'b0, 1'b1, 10'd200, 10'd240, 1'b1, 1'b0, "pad_l_face"};
        vecs[13] = '{10'd15,  10'd200, 1'b0, 1'b1, 10'd200, 10'd240, 1'b0, 1'b0, "pad_l_behind"};
        vecs[14] = '{10'd20,  10'd200, 1'b1, 1'b1, 10'd200, 10'd240, 1'b0, 1'b0, "pad_l_wrong_dir"};
        vecs[15] = '{10'd620, 10'd300, 1'b1, 1'b0, 10'd240, 10'd300, 1'b1, 1'b0, "pad_r_hit"};
        vecs[16] = '{10'd619, 10'd300, 1'b1, 1'b0, 10'd240, 10'd300, 1'b0, 1'b0, "pad_r_short"};
        vecs[17] = '{10'd624, 10'd300, 1'b1, 1'b0, 10'd240, 10'd300, 1'b1, 1'b0, "pad_r_face"};
        vecs[18] = '{10'd620, 10'd300, 1'b1, 1'b0, 10'd240, 10'd272, 1'b1, 1'b0, "pad_r_reach"};
        vecs[19] = '{10'd620, 10'd300, 1'b1, 1'b0, 10'd240, 10'd271, 1'b0, 1'b0, "pad_r_reach_out"};
        vecs[20] = '{10'd20,  10'd3,   1'b0, 1'b0, 10'd10,  10'd240, 1'b1, 1'b1, "corner"};
        vecs[21] = '{10'd20,  10'd2,   1'b0, 1'b1, 10'd0,   10'd240, 1'b1, 1'b0, "pad_l_low_y"};

        // Reset state
        #7;
        chk("rst_bounce_x", bounce_x, 1'b0);
        chk("rst_bounce_y", bounce_y, 1'b0);
        chk("rst_serve", serve, 1'b0);
        chk("rst_serve_dir", serve_dir, 1'b0);
        chk("rst_score_l", score_l, 4'd0);
        chk("rst_score_r", score_r, 4'd0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_winner", winner, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Ticks in IDLE do nothing
        drive_tick(10'd320, 10'd3, 1'b0, 1'b0, 10'd240, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "idle_tick");

        // Start and serve after 60 frames
        pulse_start();
        serve_wait(1'b1);

        // Collision table
        foreach (vecs[i])
            drive_tick(vecs[i].x, vecs[i].y, vecs[i].dx, vecs[i].dy, vecs[i].pl, vecs[i].pr,
                       vecs[i].bx, vecs[i].by, 1'b0, 1'b0, vecs[i].name);

        // Right-side miss: point to left player
        drive_tick(10'd635, 10'd200, 1'b1, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "miss_r");
        chk("miss_r_score_l", score_l, 4'd1);
        chk("miss_r_score_r", score_r, 4'd0);
        chk("miss_r_serve_dir", serve_dir, 1'b1);
        serve_wait(1'b1);

        // Seven left-side misses: right player wins
        for (int k = 1; k <= 7; k++) begin
            drive_tick(10'd4, 10'd200, 1'b0, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "miss_l");
            chk("miss_l_score_r", score_r, k);
            chk("miss_l_serve_dir", serve_dir, 1'b0);
            if (k < 7) serve_wait(1'b0);
        end
        @(negedge clk);
        chk("over_game_over", game_over, 1'b1);
        chk("over_winner", winner, 1'b1);
        chk("over_score_r", score_r, 4'd7);
        chk("over_score_l", score_l, 4'd1);

        // No pulses in OVER, scores hold
        for (int i = 0; i < 3; i++)
            drive_tick(10'd20, 10'd3, 1'b0, 1'b0, 10'd10, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "over_tick");
        chk("over_hold_score_r", score_r, 4'd7);
        chk("over_hold_game_over", game_over, 1'b1);

        // Restart
        pulse_start();
        @(negedge clk);
        chk("restart_score_l", score_l, 4'd0);
        chk("restart_score_r", score_r, 4'd0);
        chk("restart_game_over", game_over, 1'b0);
        chk("restart_serve_dir", serve_dir, 1'b1);
        serve_wait(1'b1);
        drive_tick(10'd635, 10'd200, 1'b1, 1'b1, 10'd240, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "miss_r2");
        chk("miss_r2_score_l", score_l, 4'd1);
        serve_wait(1'b1);

        // Reset between tick and pulse
        @(negedge clk);
        #1;
        ball_x = 10'd320; ball_y = 10'd3; ball_dx = 1'b0; ball_dy = 1'b0;
        frame_tick = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_score_l", score_l, 4'd0);
        chk("arst_serve_dir", serve_dir, 1'b0);
        chk("arst_bounce_y", bounce_y, 1'b0);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk("arst_hold_bounce_y", bounce_y, 1'b0);
        chk("arst_hold_game_over", game_over, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_tick(10'd320, 10'd3, 1'b0, 1'b0, 10'd240, 10'd240, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
